// File: rtl/xmit_pkg.sv
// xmit_pkg
//   Shared definitions for the PHY nibble path (receive and transmit sides).
//   Provides the receive FSM state type, frame error codes, preamble/SFD
//   nibble values, the length field width and the control-block pack
//   function {len, len} that the transmit side also consumes.
package xmit_pkg;

  localparam int LEN_W  = 12;
  localparam int CTRL_W = 2 * LEN_W;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_ODD      = 2'd1;
  localparam logic [1:0] ERR_RUNT     = 2'd2;
  localparam logic [1:0] ERR_OVERSIZE = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  // The control block carries the length twice so the consumer can
  // cross-check the two halves.
  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [LEN_W-1:0] len);
    return {len, len};
  endfunction

endpackage

// File: rtl/xmit_phy_rx_if.sv
// xmit_phy_rx_if
//   Bundles the PHY-side nibble inputs and the frame-buffer-side outputs of
//   the receive path.
//   PHY side:    phy_rx_dv, phy_data_in[3:0]
//   Buffer side: r_data_out[7:0], r_data_valid, r_ctrl_out[23:0],
//                r_ctrl_valid, r_frame_err, r_err_code[1:0],
//                r_good_frames[15:0]
//   The slave modport is the receiver itself; the master modport is whatever
//   drives the pins and consumes the bytes.
interface xmit_phy_rx_if;
  import xmit_pkg::*;

  logic              phy_rx_dv;
  logic [3:0]        phy_data_in;
  logic [7:0]        r_data_out;
  logic              r_data_valid;
  logic [CTRL_W-1:0] r_ctrl_out;
  logic              r_ctrl_valid;
  logic              r_frame_err;
  logic [1:0]        r_err_code;
  logic [15:0]       r_good_frames;

  modport master (
    output phy_rx_dv, phy_data_in,
    input  r_data_out, r_data_valid, r_ctrl_out, r_ctrl_valid,
           r_frame_err, r_err_code, r_good_frames
  );

  modport slave (
    input  phy_rx_dv, phy_data_in,
    output r_data_out, r_data_valid, r_ctrl_out, r_ctrl_valid,
           r_frame_err, r_err_code, r_good_frames
  );

endinterface

// File: rtl/xmit_nib2byte.sv
// xmit_nib2byte
//   Pairs receive nibbles into bytes, low nibble first, and strobes each
//   completed byte for one cycle.
//   clk_phy, reset_n : clock, async active-low reset
//   clear            : holds the nibble phase at even (outside a frame body)
//   nib_en           : a payload nibble is present this cycle
//   nibble[3:0]      : payload nibble
//   allow            : completed byte may be emitted (not past max length)
//   phase            : 1 = a low nibble is latched and its partner pending
//   byte_out[7:0]    : last emitted byte, held between strobes
//   byte_valid       : one-cycle strobe per emitted byte
module xmit_nib2byte (
  input  logic       clk_phy,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       nib_en,
  input  logic [3:0] nibble,
  input  logic       allow,
  output logic       phase,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [3:0] lo_nib;

  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= 1'b0;
      lo_nib     <= 4'h0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clear) begin
        phase <= 1'b0;
      end else if (nib_en) begin
        if (!phase) begin
          lo_nib <= nibble;
          phase  <= 1'b1;
        end else begin
          phase <= 1'b0;
          // Suppressed bytes still complete the pair so the phase stays true.
          if (allow) begin
            byte_out   <= {nibble, lo_nib};
            byte_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/xmit_phy_rx.sv
// xmit_phy_rx
//   Receive side of the PHY nibble interface. Hunts preamble/SFD, hands the
//   payload nibbles to xmit_nib2byte for byte assembly, tracks length and
//   errors, and at end of frame emits the {len, len} control block with an
//   error flag/code and a running count of good frames.
//   clk_phy        : PHY nibble clock, rising edge
//   reset_n        : async active-low reset; aborts any frame in progress
//   bus (slave)    : phy_rx_dv/phy_data_in in; r_data_*, r_ctrl_*,
//                    r_frame_err, r_err_code, r_good_frames out
module xmit_phy_rx
  import xmit_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 2048,
  parameter int unsigned PRE_MIN = 2
) (
  input  logic         clk_phy,
  input  logic         reset_n,
  xmit_phy_rx_if.slave bus
);

  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT   = '1;
  localparam logic [3:0]       PRE_MIN_C = 4'(PRE_MIN);

  state_t            state;
  logic [3:0]        pre_cnt;
  logic [LEN_W-1:0]  len;
  logic              oversize;
  logic              phase;
  logic              nib_en;
  logic              allow;
  logic [1:0]        end_code;
  logic [7:0]        byte_out;
  logic              byte_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic              ctrl_valid;
  logic              frame_err;
  logic [1:0]        err_code;
  logic [15:0]       good_frames;

  assign nib_en = (state == DATA) && bus.phy_rx_dv;
  assign allow  = (len < MAX_LEN_C);

  xmit_nib2byte u_nib2byte (
    .clk_phy    (clk_phy),
    .reset_n    (reset_n),
    .clear      (state != DATA),
    .nib_en     (nib_en),
    .nibble     (bus.phy_data_in),
    .allow      (allow),
    .phase      (phase),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  // End-of-frame verdict: oversize beats a dangling half byte, which beats runt.
  always_comb begin
    end_code = ERR_OK;
    if (oversize)             end_code = ERR_OVERSIZE;
    else if (phase)           end_code = ERR_ODD;
    else if (len < MIN_LEN_C) end_code = ERR_RUNT;
  end

  always_ff @(posedge clk_phy or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pre_cnt     <= 4'd0;
      len         <= '0;
      oversize    <= 1'b0;
      ctrl_out    <= '0;
      ctrl_valid  <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_OK;
      good_frames <= 16'd0;
    end else begin
      ctrl_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.phy_rx_dv) begin
            if (bus.phy_data_in == PREAMBLE_NIB) begin
              state   <= PRE;
              pre_cnt <= 4'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!bus.phy_rx_dv) begin
            state <= IDLE;
          end else if (bus.phy_data_in == PREAMBLE_NIB) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if ((bus.phy_data_in == SFD_NIB) && (pre_cnt >= PRE_MIN_C)) begin
            state    <= DATA;
            len      <= '0;
            oversize <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (bus.phy_rx_dv) begin
            // Length advances on the high nibble, i.e. when a byte completes.
            if (phase) begin
              if (!allow) oversize <= 1'b1;
              if (len != LEN_SAT) len <= len + 1'b1;
            end
          end else begin
            state      <= IDLE;
            ctrl_valid <= 1'b1;
            ctrl_out   <= pack_ctrl(len);
            frame_err  <= (end_code != ERR_OK);
            err_code   <= end_code;
            if (end_code == ERR_OK) good_frames <= good_frames + 16'd1;
          end
        end
        DROP: begin
          if (!bus.phy_rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_data_out    = byte_out;
  assign bus.r_data_valid  = byte_valid;
  assign bus.r_ctrl_out    = ctrl_out;
  assign bus.r_ctrl_valid  = ctrl_valid;
  assign bus.r_frame_err   = frame_err;
  assign bus.r_err_code    = err_code;
  assign bus.r_good_frames = good_frames;

endmodule

// File: tb/tb_xmit_phy_rx.sv
// tb_xmit_phy_rx
//   Scoreboard bench for xmit_phy_rx: frame senders push expected bytes and
//   control records; a negedge monitor collects what the receiver strobes;
//   each test task then pops and compares both queues.
module tb_xmit_phy_rx;
  import xmit_pkg::*;

  typedef struct packed {
    logic [23:0] ctrl;
    logic        err;
    logic [1:0]  code;
    logic [15:0] good;
  } ctrl_rec_t;

  logic clk_phy = 1'b0;
  logic reset_n;

  xmit_phy_rx_if bus();

  xmit_phy_rx #(.MIN_LEN(64), .MAX_LEN(2048), .PRE_MIN(2)) dut (
    .clk_phy (clk_phy),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_phy = ~clk_phy;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_bytes[$];
  logic [7:0] obs_bytes[$];
  ctrl_rec_t  exp_ctrl[$];
  ctrl_rec_t  obs_ctrl[$];
  logic [15:0] model_good = 16'd0;

  // Collect every strobe the receiver produces.
  always @(negedge clk_phy) begin
    if (reset_n === 1'b1) begin
      if (bus.r_data_valid === 1'b1) obs_bytes.push_back(bus.r_data_out);
      if (bus.r_ctrl_valid === 1'b1)
        obs_ctrl.push_back({bus.r_ctrl_out, bus.r_frame_err, bus.r_err_code, bus.r_good_frames});
    end
  end

  task automatic drive_nib(input logic dv, input logic [3:0] n);
    @(negedge clk_phy);
    bus.phy_rx_dv   = dv;
    bus.phy_data_in = n;
  endtask

  // Sends one frame and pushes what the receiver should report for it.
  // abort_at >= 0 stops driving right after that byte (no control expected).
  task automatic send_frame(input int npre, input int nbytes, input bit extra,
                            input int gap, input int seed, input int abort_at);
    logic [7:0]  b;
    logic [11:0] l;
    ctrl_rec_t   r;
    for (int i = 0; i < npre; i++) drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'(i + seed);
      drive_nib(1'b1, b[3:0]);
      drive_nib(1'b1, b[7:4]);
      if (i < 2048) exp_bytes.push_back(b);
      if (abort_at >= 0 && i == abort_at) return;
    end
    if (extra) drive_nib(1'b1, 4'h3);
    for (int i = 0; i < gap; i++) drive_nib(1'b0, 4'h0);
    l = (nbytes > 4095) ? 12'hFFF : 12'(nbytes);
    r.ctrl = {l, l};
    if (nbytes > 2048)    r.code = 2'd3;
    else if (extra)       r.code = 2'd1;
    else if (nbytes < 64) r.code = 2'd2;
    else                  r.code = 2'd0;
    r.err = (r.code != 2'd0);
    if (!r.err) model_good = model_good + 16'd1;
    r.good = model_good;
    exp_ctrl.push_back(r);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_phy);
    #1;
    total++;
    if (bus.r_data_valid !== 1'b0) $display("[TB] FAIL reset data_valid: observed %b expected 0", bus.r_data_valid);
    else passed++;
    total++;
    if (bus.r_data_out !== 8'h00) $display("[TB] FAIL reset data_out: observed %h expected 00", bus.r_data_out);
    else passed++;
    total++;
    if (bus.r_ctrl_valid !== 1'b0) $display("[TB] FAIL reset ctrl_valid: observed %b expected 0", bus.r_ctrl_valid);
    else passed++;
    total++;
    if (bus.r_ctrl_out !== 24'h0) $display("[TB] FAIL reset ctrl_out: observed %h expected 000000", bus.r_ctrl_out);
    else passed++;
    total++;
    if ({bus.r_frame_err, bus.r_err_code} !== 3'b000)
      $display("[TB] FAIL reset err: observed %b%b expected 000", bus.r_frame_err, bus.r_err_code);
    else passed++;
    total++;
    if (bus.r_good_frames !== 16'h0) $display("[TB] FAIL reset good_frames: observed %h expected 0000", bus.r_good_frames);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk_phy);
  endtask

  task automatic test_good_frame;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(7, 512, 1'b0, 2, 0, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL good_frame byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL good_frame byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL good_frame ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL good_frame ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  task automatic test_runt;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(7, 32, 1'b0, 2, 5, -1);
    send_frame(7, 64, 1'b0, 2, 9, -1);
    send_frame(7, 0, 1'b0, 2, 0, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL runt byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL runt byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL runt ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL runt ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  task automatic test_odd_nibbles;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(7, 64, 1'b1, 2, 3, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL odd byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL odd byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL odd ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL odd ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  task automatic test_oversize;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(7, 2100, 1'b0, 2, 0, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL oversize byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL oversize byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL oversize ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL oversize ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  task automatic test_bad_preamble;
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hA);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
    for (int i = 0; i < 8; i++) drive_nib(1'b1, 4'(i));
    drive_nib(1'b0, 4'h0);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
    for (int i = 0; i < 8; i++) drive_nib(1'b1, 4'(i + 3));
    drive_nib(1'b0, 4'h0);
    drive_nib(1'b0, 4'h0);
    repeat (3) @(negedge clk_phy);
    #1;
    total++;
    if (obs_bytes.size() != 0) $display("[TB] FAIL bad_preamble bytes: observed %0d strobes expected 0", obs_bytes.size());
    else passed++;
    total++;
    if (obs_ctrl.size() != 0) $display("[TB] FAIL bad_preamble ctrl: observed %0d strobes expected 0", obs_ctrl.size());
    else passed++;
    total++;
    if (bus.r_good_frames !== model_good)
      $display("[TB] FAIL bad_preamble good_frames: observed %h expected %h", bus.r_good_frames, model_good);
    else passed++;
    obs_bytes.delete();
    obs_ctrl.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(2, 64, 1'b0, 1, 8'h10, -1);
    send_frame(3, 70, 1'b0, 1, 8'h80, -1);
    send_frame(2, 40, 1'b0, 2, 8'h33, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL b2b byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL b2b byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL b2b ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL b2b ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] eb, ob;
    ctrl_rec_t  ec, oc;
    send_frame(7, 200, 1'b0, 1, 0, 99);
    @(negedge clk_phy);
    #1;
    reset_n = 1'b0;
    model_good = 16'd0;
    #1;
    total++;
    if ({bus.r_data_out, bus.r_data_valid, bus.r_ctrl_out, bus.r_ctrl_valid,
         bus.r_frame_err, bus.r_err_code, bus.r_good_frames} !== 53'd0)
      $display("[TB] FAIL mid_reset outputs: observed %h/%b/%h/%b/%b/%h/%h expected all zero",
               bus.r_data_out, bus.r_data_valid, bus.r_ctrl_out, bus.r_ctrl_valid,
               bus.r_frame_err, bus.r_err_code, bus.r_good_frames);
    else passed++;
    bus.phy_rx_dv   = 1'b0;
    bus.phy_data_in = 4'h0;
    repeat (2) @(negedge clk_phy);
    #1;
    reset_n = 1'b1;
    send_frame(7, 64, 1'b0, 2, 8'h40, -1);
    repeat (3) @(negedge clk_phy);
    #1;
    while (exp_bytes.size() > 0 || obs_bytes.size() > 0) begin
      total++;
      if (exp_bytes.size() == 0 || obs_bytes.size() == 0) begin
        $display("[TB] FAIL mid_reset byte count: observed %0d left, expected %0d left", obs_bytes.size(), exp_bytes.size());
        exp_bytes.delete(); obs_bytes.delete();
      end else begin
        eb = exp_bytes.pop_front(); ob = obs_bytes.pop_front();
        if (ob !== eb) $display("[TB] FAIL mid_reset byte: observed %h expected %h", ob, eb);
        else passed++;
      end
    end
    while (exp_ctrl.size() > 0 || obs_ctrl.size() > 0) begin
      total++;
      if (exp_ctrl.size() == 0 || obs_ctrl.size() == 0) begin
        $display("[TB] FAIL mid_reset ctrl count: observed %0d left, expected %0d left", obs_ctrl.size(), exp_ctrl.size());
        exp_ctrl.delete(); obs_ctrl.delete();
      end else begin
        ec = exp_ctrl.pop_front(); oc = obs_ctrl.pop_front();
        if (oc !== ec) $display("[TB] FAIL mid_reset ctrl: observed %h expected %h", oc, ec);
        else passed++;
      end
    end
  endtask

  initial begin
    bus.phy_rx_dv   = 1'b0;
    bus.phy_data_in = 4'h0;
    reset_n         = 1'b0;
    $display("[TB] starting xmit_phy_rx tests");
    test_reset;
    test_good_frame;
    test_runt;
    test_odd_nibbles;
    test_oversize;
    test_bad_preamble;
    test_back_to_back;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/xmit_phy_rx.md
Name: xmit_phy_rx

Overview:
- Receive-side counterpart of the transmit path's PHY nibble interface.
- Hunts preamble/SFD on a 4-bit MII-style nibble stream and reassembles bytes, low nibble first.
- Streams bytes out with a valid strobe, then emits a 24-bit control block in the same format the transmit side consumes: {len[11:0], len[11:0]}, e.g. 512 bytes -> 24'h200200.
- Single clock domain on clk_phy; sits between the PHY pins and the receive frame buffer.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes; shorter frames are flagged as runts.
- MAX_LEN, 2048, maximum legal length in bytes; bytes beyond it are suppressed and the frame is flagged. Must be ≤ 4095.
- PRE_MIN, 2, minimum count of 0x5 preamble nibbles required before SFD 0xD.

Ports:
- clk_phy  in  1  PHY nibble clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- phy_rx_dv  in  1  receive data valid; high for the whole frame, including preamble.
- phy_data_in  in  4  receive nibble.
- r_data_out  out  8  assembled byte.
- r_data_valid  out  1  one-cycle strobe per byte.
- r_ctrl_out  out  24  {len, len}; len = bytes received, saturating at 4095.
- r_ctrl_valid  out  1  one-cycle end-of-frame strobe.
- r_frame_err  out  1  valid with r_ctrl_valid; 1 = frame bad.
- r_err_code  out  2  0 ok, 1 odd nibble count, 2 runt, 3 oversize. Priority: 3 > 1 > 2.
- r_good_frames  out  16  count of error-free frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Assertion mid-frame aborts immediately; no ctrl strobe is issued for the aborted frame.
- FSM states:
  - IDLE: on dv=1, nibble 0x5 -> PRE with pre_cnt=1; any other nibble -> DROP.
  - PRE: on dv=1, nibble 0x5 -> pre_cnt++ (saturating at 15).
    - Nibble 0xD with pre_cnt ≥ PRE_MIN -> DATA, clearing len, the nibble phase and error flags.
    - Nibble 0xD with pre_cnt < PRE_MIN, or any other nibble -> DROP.
    - dv=0 -> IDLE silently.
  - DATA, dv=1, even phase: latch nibble as byte[3:0].
  - DATA, dv=1, odd phase: byte = {nibble, latched}.
    - If len < MAX_LEN: r_data_out=byte and r_data_valid=1 in the next cycle.
    - Else: no strobe; set the oversize flag.
    - In both cases, len++ (saturating).
  - DATA, dv=0 -> IDLE. Next cycle: r_ctrl_valid=1, r_ctrl_out={len,len}, r_frame_err and r_err_code per the priority above. Odd phase pending means a half byte; it is discarded and counted as odd nibble count. If the frame is error-free, r_good_frames++ in the same cycle.
  - DROP: wait for dv=0 -> IDLE. No outputs.
- Latency:
  - Byte strobe is 1 cycle after the edge that samples the high nibble.
  - Ctrl strobe is 1 cycle after the edge that samples dv=0.
  - r_data_out and r_ctrl_out hold their last value when the strobe is low.
- Minimum inter-frame gap is 1 cycle of dv=0. The ctrl strobe may coincide with the first preamble nibble of the next frame; both must be handled.
- A 0x0-length frame (SFD then dv=0) produces a runt with len=0 and ctrl 24'h000000.
- A ctrl strobe never coincides with a data strobe of the same frame.

Decomposition:
- Shared package (xmit_pkg):
  - state enum IDLE/PRE/DATA/DROP;
  - ERR_* codes;
  - PREAMBLE_NIB=4'h5, SFD_NIB=4'hD;
  - LEN_W=12;
  - a ctrl-block pack function {len,len} reused with the transmit side.
- One natural sub-module: xmit_nib2byte, the nibble-phase register plus byte assembly and valid strobe. The FSM, length/error tracking and good-frame counter stay in the top.

Test Plan:
- Good frame: reset_n low 3 cycles. Then 7×0x5, 0xD, and 1024 nibbles forming bytes 0x00..0xFF repeating (512 bytes), then dv=0 -> 512 strobes with correct bytes, r_ctrl_out=24'h200200, err=0, r_good_frames=1.
- Runt: 64-nibble frame (32 bytes) -> 32 strobes, ctrl 24'h020020, err=1, code=2, good count unchanged. A 64-byte frame gives 24'h040040, err=0.
- Odd nibbles: 129 payload nibbles -> 64 strobes, ctrl 24'h040040, code=1.
- Oversize: 2100-byte frame -> exactly 2048 strobes, ctrl 24'h834834, code=3.
- Bad preamble: 0x5,0xA,... -> DROP, no strobes of any kind. A 0x5,0xD-only preamble with PRE_MIN=2 is also dropped. A back-to-back frame after a 1-cycle gap is received correctly.
- Reset mid-frame: assert reset_n at byte 100 -> all outputs 0 immediately, no ctrl strobe. The following good 64-byte frame is received normally.
